// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the three slaves.
// The master modport is the arbiter's view; the slave modport is the view of
// the surrounding masters/slaves that drive and consume the arbiter.
interface bus_arbiter_if;
    // Master 0 / master 1 request side
    logic [31:0] m0_address;
    logic [31:0] m1_address;
    logic        m0_rw_req;
    logic        m1_rw_req;
    logic        m0_rw;
    logic        m1_rw;
    logic [31:0] m0_write_data;
    logic [31:0] m1_write_data;
    logic [1:0]  m0_size;
    logic [1:0]  m1_size;
    logic [31:0] m0_read_data;
    logic [31:0] m1_read_data;
    logic        m0_rec;
    logic        m1_rec;

    // Shared slave side
    logic [31:0] s_address;
    logic        s_rw;
    logic [31:0] s_write_data;
    logic [1:0]  s_size;
    logic        mem_req;
    logic        sdram_req;
    logic        per_req;
    logic [31:0] mem_read_data;
    logic [31:0] sdram_read_data;
    logic [31:0] per_read_data;
    logic        mem_valid;
    logic        sdram_valid;
    logic        per_valid;

    // Status
    logic        grant;
    logic        timeout_err;

    modport master (
        input  m0_address, m1_address, m0_rw_req, m1_rw_req, m0_rw, m1_rw,
               m0_write_data, m1_write_data, m0_size, m1_size,
               mem_read_data, sdram_read_data, per_read_data,
               mem_valid, sdram_valid, per_valid,
        output m0_read_data, m1_read_data, m0_rec, m1_rec,
               s_address, s_rw, s_write_data, s_size,
               mem_req, sdram_req, per_req, grant, timeout_err
    );

    modport slave (
        output m0_address, m1_address, m0_rw_req, m1_rw_req, m0_rw, m1_rw,
               m0_write_data, m1_write_data, m0_size, m1_size,
               mem_read_data, sdram_read_data, per_read_data,
               mem_valid, sdram_valid, per_valid,
        input  m0_read_data, m1_read_data, m0_rec, m1_rec,
               s_address, s_rw, s_write_data, s_size,
               mem_req, sdram_req, per_req, grant, timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, three-slave bus arbiter with round-robin grant, address decode
// into per-slave strobes, registered data return and a no-response watchdog.
module bus_arbiter #(
    parameter logic [31:0] MEM_LIMIT = 32'h0003_0000,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input logic           clk,
    input logic           reset,
    bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    // Counter value seen on the last BUSY cycle before the watchdog fires.
    localparam logic [31:0] LastCount = 32'(TIMEOUT - 1);

    state_t      state;
    logic        rr_m1;     // 1: m1 wins when both masters request
    logic [31:0] count;

    logic        pick_m1;
    logic [31:0] req_address;
    logic        req_rw;
    logic [31:0] req_write_data;
    logic [1:0]  req_size;
    logic        dec_mem;
    logic        dec_sdram;
    logic        dec_per;
    logic        sel_valid;
    logic [31:0] sel_data;
    logic        granted_req;

    // Arbitration, field mux, address decode and selected-slave return path.
    always_comb begin
        if (bus.m0_rw_req && bus.m1_rw_req) begin
            pick_m1 = rr_m1;
        end else begin
            pick_m1 = bus.m1_rw_req;
        end

        req_address    = pick_m1 ? bus.m1_address    : bus.m0_address;
        req_rw         = pick_m1 ? bus.m1_rw         : bus.m0_rw;
        req_write_data = pick_m1 ? bus.m1_write_data : bus.m0_write_data;
        req_size       = pick_m1 ? bus.m1_size       : bus.m0_size;

        dec_per   = req_address[31];
        dec_mem   = !req_address[31] && (req_address < MEM_LIMIT);
        dec_sdram = !req_address[31] && !(req_address < MEM_LIMIT);

        // Only the strobed slave's valid counts; the strobes are one-hot.
        sel_valid = (bus.mem_req   && bus.mem_valid)   ||
                    (bus.sdram_req && bus.sdram_valid) ||
                    (bus.per_req   && bus.per_valid);

        sel_data = '0;
        if (bus.mem_req) begin
            sel_data = bus.mem_read_data;
        end else if (bus.sdram_req) begin
            sel_data = bus.sdram_read_data;
        end else if (bus.per_req) begin
            sel_data = bus.per_read_data;
        end

        granted_req = bus.grant ? bus.m1_rw_req : bus.m0_rw_req;
    end

    // Transaction FSM; every bus output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= StIdle;
            rr_m1            <= 1'b0;
            count            <= '0;
            bus.grant        <= 1'b0;
            bus.timeout_err  <= 1'b0;
            bus.s_address    <= '0;
            bus.s_rw         <= 1'b0;
            bus.s_write_data <= '0;
            bus.s_size       <= '0;
            bus.mem_req      <= 1'b0;
            bus.sdram_req    <= 1'b0;
            bus.per_req      <= 1'b0;
            bus.m0_rec       <= 1'b0;
            bus.m1_rec       <= 1'b0;
            bus.m0_read_data <= '0;
            bus.m1_read_data <= '0;
        end else begin
            bus.timeout_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.m0_rw_req || bus.m1_rw_req) begin
                        bus.grant        <= pick_m1;
                        rr_m1            <= !pick_m1;
                        bus.s_address    <= req_address;
                        bus.s_rw         <= req_rw;
                        bus.s_write_data <= req_write_data;
                        bus.s_size       <= req_size;
                        bus.mem_req      <= dec_mem;
                        bus.sdram_req    <= dec_sdram;
                        bus.per_req      <= dec_per;
                        count            <= '0;
                        state            <= StBusy;
                    end
                end
                StBusy: begin
                    if (sel_valid || count == LastCount) begin
                        // Slave answered, or the watchdog gives up on it.
                        if (bus.grant) begin
                            bus.m1_read_data <= sel_valid ? sel_data : ERR_DATA;
                            bus.m1_rec       <= 1'b1;
                        end else begin
                            bus.m0_read_data <= sel_valid ? sel_data : ERR_DATA;
                            bus.m0_rec       <= 1'b1;
                        end
                        bus.timeout_err <= !sel_valid;
                        bus.mem_req     <= 1'b0;
                        bus.sdram_req   <= 1'b0;
                        bus.per_req     <= 1'b0;
                        state           <= StDone;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                StDone: begin
                    if (!granted_req) begin
                        bus.m0_rec <= 1'b0;
                        bus.m1_rec <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, decode, data return, round-robin,
// watchdog timeout and asynchronous reset during a transaction.
module tb_bus_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    bus_arbiter_if bus ();

    bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [2:0] strb;
    assign strb = {bus.mem_req, bus.sdram_req, bus.per_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Outputs are sampled, and inputs changed, on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input bit m, input logic [31:0] addr, input bit rw,
                           input logic [31:0] wd, input bit on);
        if (m) begin
            bus.m1_address = addr; bus.m1_rw = rw; bus.m1_write_data = wd;
            bus.m1_size = 2'd1; bus.m1_rw_req = on;
        end else begin
            bus.m0_address = addr; bus.m0_rw = rw; bus.m0_write_data = wd;
            bus.m0_size = 2'd2; bus.m0_rw_req = on;
        end
    endtask

    task automatic set_valid(input logic [2:0] which, input logic [31:0] rd);
        bus.mem_valid   = which[2]; bus.mem_read_data   = rd;
        bus.sdram_valid = which[1]; bus.sdram_read_data = rd;
        bus.per_valid   = which[0]; bus.per_read_data   = rd;
    endtask

    // One full transaction from an idle arbiter with the slave answering in
    // the first strobe cycle.
    task automatic txn(input string tag, input bit m, input logic [31:0] addr,
                       input bit rw, input logic [31:0] wd,
                       input logic [2:0] exp_strb, input logic [31:0] rd);
        set_req(m, addr, rw, wd, 1'b1);
        tick();
        chk({tag, " strobe"}, 32'(strb), 32'(exp_strb));
        chk({tag, " grant"}, 32'(bus.grant), 32'(m));
        chk({tag, " s_address"}, bus.s_address, addr);
        chk({tag, " s_rw"}, 32'(bus.s_rw), 32'(rw));
        chk({tag, " s_write_data"}, bus.s_write_data, wd);
        chk({tag, " s_size"}, 32'(bus.s_size), m ? 32'd1 : 32'd2);
        set_valid(exp_strb, rd);
        tick();
        chk({tag, " rec"}, 32'({bus.m1_rec, bus.m0_rec}), m ? 32'd2 : 32'd1);
        chk({tag, " read_data"}, m ? bus.m1_read_data : bus.m0_read_data, rd);
        chk({tag, " strobe dropped"}, 32'(strb), 32'd0);
        set_valid(3'b000, 32'h0);
        set_req(m, addr, rw, wd, 1'b0);
        tick();
        chk({tag, " rec low"}, 32'({bus.m1_rec, bus.m0_rec}), 32'd0);
    endtask

    initial begin
        int n;
        int early;
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        bus.m0_address = '0; bus.m0_rw = 1'b0; bus.m0_write_data = '0; bus.m0_size = '0;
        bus.m1_address = '0; bus.m1_rw = 1'b0; bus.m1_write_data = '0; bus.m1_size = '0;
        bus.m0_rw_req = 1'b0; bus.m1_rw_req = 1'b0;
        set_valid(3'b000, 32'h0);

        // Reset held with both masters requesting.
        set_req(1'b0, 32'h0000_0100, 1'b0, 32'h0, 1'b1);
        set_req(1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
        repeat (3) tick();
        chk("reset strobe", 32'(strb), 32'd0);
        chk("reset rec", 32'({bus.m1_rec, bus.m0_rec}), 32'd0);
        chk("reset grant", 32'(bus.grant), 32'd0);
        chk("reset s_address", bus.s_address, 32'h0);
        chk("reset timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("reset m0_read_data", bus.m0_read_data, 32'h0);

        // Release: m0 wins the tie, mem strobe on the next edge.
        reset = 1'b1;
        tick();
        chk("first grant", 32'(bus.grant), 32'd0);
        chk("first strobe", 32'(strb), 32'b100);
        chk("first s_address", bus.s_address, 32'h0000_0100);
        bus.m1_rw_req = 1'b0;
        set_valid(3'b100, 32'hCAFE_0001);
        tick();
        chk("first rec", 32'({bus.m1_rec, bus.m0_rec}), 32'd1);
        chk("first data", bus.m0_read_data, 32'hCAFE_0001);
        set_valid(3'b000, 32'h0);
        bus.m0_rw_req = 1'b0;
        tick();
        chk("first rec low", 32'({bus.m1_rec, bus.m0_rec}), 32'd0);

        // m0 read at top of mem; other valids ignored; fields latched at grant.
        set_req(1'b0, 32'h0002_FFFC, 1'b0, 32'h0, 1'b1);
        tick();
        chk("mem top strobe", 32'(strb), 32'b100);
        bus.m0_address = 32'h1234_0000;
        set_valid(3'b011, 32'hFFFF_FFFF);
        tick();
        chk("foreign valid rec", 32'({bus.m1_rec, bus.m0_rec}), 32'd0);
        chk("foreign valid strobe", 32'(strb), 32'b100);
        chk("latched s_address", bus.s_address, 32'h0002_FFFC);
        set_valid(3'b100, 32'h1234_5678);
        tick();
        chk("mem top rec", 32'({bus.m1_rec, bus.m0_rec}), 32'd1);
        chk("mem top data", bus.m0_read_data, 32'h1234_5678);
        set_valid(3'b000, 32'h0);
        tick();
        chk("rec held", 32'(bus.m0_rec), 32'd1);
        bus.m0_rw_req = 1'b0;
        tick();
        chk("rec dropped", 32'(bus.m0_rec), 32'd0);
        chk("data kept", bus.m0_read_data, 32'h1234_5678);

        // Boundary at MEM_LIMIT, then an m1 peripheral write.
        txn("sdram base", 1'b0, 32'h0003_0000, 1'b0, 32'h0, 3'b010, 32'h0BAD_F00D);
        txn("per write", 1'b1, 32'h8000_0004, 1'b1, 32'h0000_00A5, 3'b001, 32'h0000_5A5A);

        // Both masters keep requesting; winner re-requests after its rec drops.
        set_req(1'b0, 32'h0000_0040, 1'b0, 32'h0, 1'b1);
        set_req(1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr grant", 32'(bus.grant), 32'(i % 2));
            chk("rr strobe", 32'(strb), (i % 2) ? 32'b001 : 32'b100);
            set_valid((i % 2) ? 3'b001 : 3'b100, 32'h100 + 32'(i));
            tick();
            chk("rr rec", 32'({bus.m1_rec, bus.m0_rec}), (i % 2) ? 32'd2 : 32'd1);
            set_valid(3'b000, 32'h0);
            if (i % 2) bus.m1_rw_req = 1'b0; else bus.m0_rw_req = 1'b0;
            tick();
            chk("rr gap", 32'({strb, bus.m1_rec, bus.m0_rec}), 32'd0);
            if (i % 2) bus.m1_rw_req = 1'b1; else bus.m0_rw_req = 1'b1;
        end
        bus.m0_rw_req = 1'b0;
        bus.m1_rw_req = 1'b0;
        tick();

        // SDRAM never answers: abort after 255 BUSY cycles.
        set_req(1'b0, 32'h4000_0000, 1'b0, 32'h0, 1'b1);
        tick();
        chk("timeout strobe", 32'(strb), 32'b010);
        n = 0;
        early = 0;
        while (!bus.m0_rec && n < 400) begin
            tick();
            n++;
            if (bus.timeout_err && !bus.m0_rec) early++;
        end
        chk("timeout cycles", 32'(n), 32'd255);
        chk("timeout early pulse", 32'(early), 32'd0);
        chk("timeout err", 32'(bus.timeout_err), 32'd1);
        chk("timeout data", bus.m0_read_data, 32'hDEAD_BEEF);
        chk("timeout strobe dropped", 32'(strb), 32'd0);
        tick();
        chk("timeout err one cycle", 32'(bus.timeout_err), 32'd0);
        chk("timeout rec held", 32'(bus.m0_rec), 32'd1);
        bus.m0_rw_req = 1'b0;
        tick();

        // Asynchronous reset while BUSY on SDRAM.
        set_req(1'b1, 32'h0003_0000, 1'b0, 32'h0, 1'b1);
        tick();
        chk("busy strobe", 32'(strb), 32'b010);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async strobe", 32'(strb), 32'd0);
        chk("async rec", 32'({bus.m1_rec, bus.m0_rec}), 32'd0);
        chk("async grant", 32'(bus.grant), 32'd0);
        bus.m1_rw_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post reset idle", 32'(strb), 32'd0);
        txn("post reset", 1'b0, 32'h0000_0100, 1'b0, 32'h0, 3'b100, 32'h7777_0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
